// File: rtl/vdp_pkg.sv
// Shared types and default timing constants for the button debouncer.
package vdp_pkg;

  // Per-channel debounce / long-press state.
  typedef enum logic [2:0] {
    ST_RELEASED,
    ST_PRESS_PEND,
    ST_HELD,
    ST_LONG_HELD,
    ST_RELEASE_PEND
  } btn_state_t;

  localparam int          DEF_NUM_BTN         = 7;
  localparam int          DEF_DEBOUNCE_CYCLES = 250000;
  localparam int          DEF_LONG_CYCLES     = 25000000;
  localparam int          DEF_RESET_BTN       = 0;
  localparam logic [31:0] DEF_ACTIVE_LOW_MASK = 32'h0000_0001;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, polarity fix-up, and the
// debounce / long-press FSM with registered level and pulse outputs.
module btn_channel
  import vdp_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter logic ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic long_hold
);

  localparam int            CW        = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [1:0]    sync;
  logic          p;
  btn_state_t    state, state_nxt;
  logic [CW-1:0] hcnt, hcnt_nxt;
  logic [CW-1:0] rcnt, rcnt_nxt;
  logic          from_long, from_long_nxt;
  logic          level_nxt, press_nxt, release_nxt, long_nxt, hold_nxt;

  // Synchronize the raw pin into the clock domain.
  // NOTE: these flops reset to the idle pin level, not 0, so an active-low
  // button does not look pressed straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {2{ACTIVE_LOW}};
    else     sync <= {sync[0], pin};
  end

  assign p = sync[1] ^ ACTIVE_LOW;

  // State and counter registers.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RELEASED;
      hcnt      <= '0;
      rcnt      <= '0;
      from_long <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      rcnt      <= rcnt_nxt;
      from_long <= from_long_nxt;
    end
  end

  // Next-state and counter update; hcnt carries the press debounce count
  // straight into the hold count, rcnt times the release debounce so the
  // hold count survives a rejected release glitch.
  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_nxt     = state;
    hcnt_nxt      = hcnt;
    rcnt_nxt      = rcnt;
    from_long_nxt = from_long;
    case (state)
      ST_RELEASED: begin
        if (p) begin
          state_nxt = ST_PRESS_PEND;
          hcnt_nxt  = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!p) begin
          state_nxt = ST_RELEASED;
        end else begin
          hcnt_nxt = hcnt + CW'(1);
          if (hcnt == DEB_LAST) state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!p) begin
          state_nxt     = ST_RELEASE_PEND;
          rcnt_nxt      = '0;
          from_long_nxt = 1'b0;
        end else if (hcnt == LONG_LAST) begin
          state_nxt = ST_LONG_HELD;
        end else begin
          hcnt_nxt = hcnt + CW'(1);
        end
      end
      ST_LONG_HELD: begin
        if (!p) begin
          state_nxt     = ST_RELEASE_PEND;
          rcnt_nxt      = '0;
          from_long_nxt = 1'b1;
        end
      end
      ST_RELEASE_PEND: begin
        if (p) begin
          state_nxt = from_long ? ST_LONG_HELD : ST_HELD;
        end else if (rcnt == DEB_LAST) begin
          state_nxt = ST_RELEASED;
        end else begin
          rcnt_nxt = rcnt + CW'(1);
        end
      end
      default: state_nxt = ST_RELEASED;
    endcase
  end

  // Output decode from the transition; pulses are one per distinct edge.
  always_comb begin
    level_nxt   = (state_nxt == ST_HELD) || (state_nxt == ST_LONG_HELD) ||
                  (state_nxt == ST_RELEASE_PEND);
    press_nxt   = (state == ST_PRESS_PEND)   && (state_nxt == ST_HELD);
    release_nxt = (state == ST_RELEASE_PEND) && (state_nxt == ST_RELEASED);
    long_nxt    = (state == ST_HELD)         && (state_nxt == ST_LONG_HELD);
    hold_nxt    = (state_nxt == ST_LONG_HELD) ||
                  ((state_nxt == ST_RELEASE_PEND) && from_long_nxt);
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      long_hold     <= 1'b0;
    end else begin
      level         <= level_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      long_press    <= long_nxt;
      long_hold     <= hold_nxt;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with press/release/long-press pulses and a
// reset request raised while the designated reset button is long-held.
module btn_debounce
  import vdp_pkg::*;
#(
  parameter int               NUM_BTN         = DEF_NUM_BTN,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = NUM_BTN'(DEF_ACTIVE_LOW_MASK),
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int               LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int               RESET_BTN       = DEF_RESET_BTN
) (
  input  logic               clk_draw,
  input  logic               rst_draw,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse,  // "release" is a reserved word
  output logic [NUM_BTN-1:0] long_press,
  output logic               rst_req
);

  localparam logic [NUM_BTN-1:0] RST_SEL = NUM_BTN'(1) << RESET_BTN;

  logic [NUM_BTN-1:0] long_hold;

  if (NUM_BTN < 1 || NUM_BTN > 32) begin : g_bad_num_btn
    $error("btn_debounce: NUM_BTN must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (RESET_BTN < 0 || RESET_BTN >= NUM_BTN) begin : g_bad_reset_btn
    $error("btn_debounce: RESET_BTN must be < NUM_BTN");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clk           (clk_draw),
      .rst           (rst_draw),
      .pin           (btn[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i]),
      .long_hold     (long_hold[i])
    );
  end

  // Only the designated channel's registered long-hold flag drives rst_req.
  assign rst_req = |(long_hold & RST_SEL);

endmodule
